hex_display_scheduler: RTL and testbench
========================================

HEX_DISPLAY_SCHEDULER -- requirements
Module: hex_display_scheduler

Interface
REQ-001 Parameter SCAN_DIV, default 65536: clock cycles per digit slot; SHALL be >= 4.
REQ-002 Parameter BLANK_CYC, default 256: leading blank (anti-ghost) cycles per slot; SHALL satisfy 1 <= BLANK_CYC < SCAN_DIV.
REQ-003 clk  input  1  sole clock; all logic on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req0, req1  input  1 each  write requests; each held high until its grant.
REQ-006 val0, val1  input  16 each  hex value offered by requester 0/1; stable while its request is high.
REQ-007 gnt0, gnt1  output  1 each  one-cycle grant pulse; the value is captured on that cycle.
REQ-008 blank_en  input  1  forces all anodes off while high.
REQ-009 an  output  4  anodes, active-low; an[3] = leftmost digit (digit 0), an[0] = digit 3.
REQ-010 seg  output  8  cathodes, active-low, order {a,b,c,d,e,f,g,dp} with seg[7]=a.
REQ-011 frame_tick  output  1  one-cycle pulse on each commit/frame boundary.

Function
REQ-012 Slot counter 0..SCAN_DIV-1 and digit index 0..3 SHALL advance every clock; at count SCAN_DIV-1 the counter SHALL wrap to 0 and the digit index SHALL increment, wrapping 3->0.
REQ-013 Per slot, FSM state BLANK SHALL hold for counts 0..BLANK_CYC-1 and state SHOW for counts BLANK_CYC..SCAN_DIV-1; the transition SHOW->BLANK SHALL occur on every slot wrap.
REQ-014 In BLANK, or while blank_en=1: an=4'b1111 and seg=8'hFF.
REQ-015 In SHOW for digit d: the an bit for digit d SHALL be low, the others high, and seg SHALL be the code of nibble disp[15-4d -: 4]; digit 0 SHALL show disp[15:12].
REQ-016 Nibble codes (hex): 0:03 1:9F 2:25 3:0D 4:99 5:49 6:41 7:1F 8:01 9:09 A:11 B:C1 C:63 D:85 E:61 F:71; dp SHALL always be off (bit0=1).
REQ-017 an and seg SHALL be registered, lagging the internal state by exactly 1 clock.
REQ-018 Registers: disp[15:0] (displayed value), shadow[15:0], pending flag, rr pointer (1 bit, the next-favoured requester).
REQ-019 A grant SHALL be issued only in a cycle where pending=0 and at least one request is high; at most one grant per cycle.
REQ-020 If only one request is high, that requester SHALL be granted; if both are high, the requester named by rr SHALL be granted and rr SHALL then point to the other requester.
REQ-021 On a grant, shadow SHALL load the granted val and pending SHALL be set in the same edge.
REQ-022 While pending=1, requests SHALL stall (no grant) regardless of requester.
REQ-023 Commit SHALL occur on the edge where digit=3 and count=SCAN_DIV-1: if pending=1, disp<=shadow and pending<=0; frame_tick SHALL pulse in the cycle after that edge whether or not pending was set.
REQ-024 A grant SHALL NOT be issued in the commit cycle itself, since pending is still 1 there; the next grant is possible one cycle later.
REQ-025 disp SHALL change only at commit, so no frame ever mixes digits from two values.
REQ-026 A request that drops before its grant SHALL be ignored and leave no state behind.

Reset
REQ-027 While rst=1, regardless of clk: count=0, digit=0, state=BLANK, disp=16'h0000, shadow=0, pending=0, rr=0 (favour req0), gnt0=gnt1=0, frame_tick=0, an=4'b1111, seg=8'hFF.
REQ-028 Reset asserted mid-slot or with pending=1 SHALL discard the pending value; after release, the first slot SHALL start at count 0, digit 0, in BLANK.

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-029 Reset release, no requests -> an=1111 for 2+1 clocks, then an=0111 with seg=03 for 6 clocks; digits 1..3 follow, each showing 03.
REQ-030 req0=1 with val0=16'h1234 at cycle 0 -> gnt0 at cycle 0, pending=1; at the first frame boundary frame_tick pulses and disp=1234; the next frame shows 9F,25,0D,99 on an=0111,1011,1101,1110.
REQ-031 req0 and req1 both high from reset (val0=AAAA, val1=5555) -> gnt0 first; gnt1 on the first cycle after the commit; the next frame shows 5555; req0 then wins the following tie.
REQ-032 Two grants requested within one frame -> the second stalls until the cycle after commit; the display never shows a mixed frame.
REQ-033 blank_en=1 during SHOW -> an=1111 and seg=FF on the next clock; counters keep running and the pattern resumes in phase on release.
REQ-034 rst pulse mid-frame with pending=1 -> outputs go to reset values immediately; disp=0000 afterwards and the pending value is never displayed.

Source files
------------

// File: rtl/hex_display_scheduler.sv
// Four-digit multiplexed hex display with a two-port write arbiter.
// Written values are double-buffered and swapped in only at frame boundaries.
module hex_display_scheduler #(
    parameter int unsigned SCAN_DIV  = 65536,
    parameter int unsigned BLANK_CYC = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] val0,
    input  logic [15:0] val1,
    output logic        gnt0,
    output logic        gnt1,
    input  logic        blank_en,
    output logic [3:0]  an,
    output logic [7:0]  seg,
    output logic        frame_tick
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] LAST    = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BL_LAST = CW'(BLANK_CYC - 1);

    typedef enum logic {BLANK, SHOW} state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]  digit_q, digit_d;
    logic [15:0] disp_q, disp_d;
    logic [15:0] shadow_q, shadow_d;
    logic        pending_q, pending_d;
    logic        rr_q, rr_d;
    logic        frame_tick_q, frame_tick_d;
    logic [3:0]  an_q, an_d;
    logic [7:0]  seg_q, seg_d;
    logic        g0, g1;
    logic        slot_end, commit;
    logic [3:0]  nib;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        logic [7:0] c;
        unique case (n)
            4'h0: c = 8'h03;
            4'h1: c = 8'h9F;
            4'h2: c = 8'h25;
            4'h3: c = 8'h0D;
            4'h4: c = 8'h99;
            4'h5: c = 8'h49;
            4'h6: c = 8'h41;
            4'h7: c = 8'h1F;
            4'h8: c = 8'h01;
            4'h9: c = 8'h09;
            4'hA: c = 8'h11;
            4'hB: c = 8'hC1;
            4'hC: c = 8'h63;
            4'hD: c = 8'h85;
            4'hE: c = 8'h61;
            default: c = 8'h71;
        endcase
        return c;
    endfunction

    assign slot_end = (count_q == LAST);
    assign commit   = slot_end && (digit_q == 2'd3);

    // Ties go to rr; any grant hands priority to the other side.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!pending_q) begin
            if (req0 && req1) begin
                g0 = !rr_q;
                g1 = rr_q;
            end else begin
                g0 = req0;
                g1 = req1;
            end
        end
    end

    assign gnt0 = g0 && !rst;
    assign gnt1 = g1 && !rst;

    always_comb begin
        unique case (digit_q)
            2'd0: nib = disp_q[15:12];
            2'd1: nib = disp_q[11:8];
            2'd2: nib = disp_q[7:4];
            default: nib = disp_q[3:0];
        endcase
    end

    always_comb begin
        count_d      = slot_end ? '0 : count_q + 1'b1;
        digit_d      = slot_end ? digit_q + 2'd1 : digit_q;
        state_d      = state_q;
        if (slot_end)
            state_d = BLANK;
        else if (count_q == BL_LAST)
            state_d = SHOW;
        disp_d       = disp_q;
        shadow_d     = shadow_q;
        pending_d    = pending_q;
        rr_d         = rr_q;
        frame_tick_d = commit;
        if (commit && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (g0 || g1) begin
            shadow_d  = g0 ? val0 : val1;
            pending_d = 1'b1;
            rr_d      = g0;
        end
        an_d  = 4'b1111;
        seg_d = 8'hFF;
        if (state_q == SHOW && !blank_en) begin
            an_d  = ~(4'b1000 >> digit_q);
            seg_d = hex7(nib);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= BLANK;
            count_q      <= '0;
            digit_q      <= 2'd0;
            disp_q       <= 16'h0000;
            shadow_q     <= 16'h0000;
            pending_q    <= 1'b0;
            rr_q         <= 1'b0;
            frame_tick_q <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 8'hFF;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            digit_q      <= digit_d;
            disp_q       <= disp_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            rr_q         <= rr_d;
            frame_tick_q <= frame_tick_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_display_scheduler.sv
// Scoreboard bench for hex_display_scheduler at SCAN_DIV=8, BLANK_CYC=2.
// Granted values are queued and matched against the frame after their commit.
module tb_hex_display_scheduler;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [15:0] val0, val1;
    logic        gnt0, gnt1;
    logic        blank_en;
    logic [3:0]  an;
    logic [7:0]  seg;
    logic        frame_tick;

    int tests = 0;
    int fails = 0;
    logic [15:0] sb_q[$];

    hex_display_scheduler #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .val0(val0), .val1(val1),
        .gnt0(gnt0), .gnt1(gnt1),
        .blank_en(blank_en),
        .an(an), .seg(seg),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] code(input logic [3:0] n);
        logic [7:0] c;
        case (n)
            4'h0: c = 8'h03;
            4'h1: c = 8'h9F;
            4'h2: c = 8'h25;
            4'h3: c = 8'h0D;
            4'h4: c = 8'h99;
            4'h5: c = 8'h49;
            4'h6: c = 8'h41;
            4'h7: c = 8'h1F;
            4'h8: c = 8'h01;
            4'h9: c = 8'h09;
            4'hA: c = 8'h11;
            4'hB: c = 8'hC1;
            4'hC: c = 8'h63;
            4'hD: c = 8'h85;
            4'hE: c = 8'h61;
            default: c = 8'h71;
        endcase
        return c;
    endfunction

    function automatic logic [31:0] frame_of(input logic [15:0] v);
        return {code(v[15:12]), code(v[11:8]), code(v[7:4]), code(v[3:0])};
    endfunction

    // Each frame spans 32 samples; the tick lands on the last one.
    task automatic run_frames(input int n, input logic [15:0] first);
        logic [15:0] exp;
        exp = first;
        for (int f = 0; f < n; f++) begin
            logic [31:0] segs;
            logic [31:0] ftm;
            logic [3:0]  seen;
            int shows;
            int first_show;
            int d;
            bit bad;
            segs = '1;
            ftm = '0;
            seen = '0;
            shows = 0;
            first_show = -1;
            bad = 1'b0;
            for (int i = 0; i < 32; i++) begin
                @(negedge clk);
                if (frame_tick) ftm[i] = 1'b1;
                case (an)
                    4'b0111: d = 0;
                    4'b1011: d = 1;
                    4'b1101: d = 2;
                    4'b1110: d = 3;
                    default: d = -1;
                endcase
                if (an == 4'b1111) begin
                    if (seg != 8'hFF) bad = 1'b1;
                end else if (d < 0) begin
                    bad = 1'b1;
                end else begin
                    shows++;
                    if (first_show < 0) first_show = i;
                    if (seen[d] && segs[8*(3-d) +: 8] != seg) bad = 1'b1;
                    segs[8*(3-d) +: 8] = seg;
                    seen[d] = 1'b1;
                end
            end
            check($sformatf("frame%0d_seg", f), segs, frame_of(exp));
            check($sformatf("frame%0d_shows", f), 32'(shows), 32'd24);
            check($sformatf("frame%0d_start", f), 32'(first_show), 32'd2);
            check($sformatf("frame%0d_mixed", f), 32'(bad), 32'd0);
            check($sformatf("frame%0d_ftick", f), ftm, 32'h8000_0000);
            if (sb_q.size() > 0) exp = sb_q.pop_front();
        end
    endtask

    task automatic wait_grant(input logic [1:0] want, input logic ftk,
                              input string tag);
        int n;
        n = 0;
        #1;
        while ({gnt0, gnt1} == 2'b00 && n < 80) begin
            @(negedge clk);
            #1;
            n++;
        end
        check({tag, "_gnt"}, 32'({gnt0, gnt1}), 32'(want));
        check({tag, "_ftk"}, 32'(frame_tick), 32'(ftk));
        if (gnt0) sb_q.push_back(val0);
        else if (gnt1) sb_q.push_back(val1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 1'b0;
        req1 = 1'b0;
        val0 = '0;
        val1 = '0;
        blank_en = 1'b0;

        // Single writer, a dropped request and a stalled second write.
        req0 = 1'b1;
        val0 = 16'h1234;
        repeat (3) @(negedge clk);
        #1;
        check("rst_an", 32'(an), 32'hF);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        check("rst_ftk", 32'(frame_tick), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        fork
            run_frames(4, 16'h0000);
            begin
                wait_grant(2'b10, 1'b0, "a0");
                req0 = 1'b0;
                repeat (4) @(negedge clk);
                req1 = 1'b1;
                val1 = 16'hDEAD;
                repeat (3) begin
                    #1;
                    check("a_stall", 32'(gnt1), 32'd0);
                    @(negedge clk);
                end
                req1 = 1'b0;
                repeat (2) @(negedge clk);
                req0 = 1'b1;
                val0 = 16'hBEEF;
                wait_grant(2'b10, 1'b1, "a1");
                req0 = 1'b0;
            end
        join

        // Contending writers alternate through the rr pointer.
        @(negedge clk);
        rst = 1'b1;
        req0 = 1'b1;
        val0 = 16'hAAAA;
        req1 = 1'b1;
        val1 = 16'h5555;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        fork
            run_frames(5, 16'h0000);
            begin
                wait_grant(2'b10, 1'b0, "b0");
                req0 = 1'b0;
                @(negedge clk);
                req0 = 1'b1;
                val0 = 16'h1111;
                wait_grant(2'b01, 1'b1, "b1");
                req1 = 1'b0;
                @(negedge clk);
                req1 = 1'b1;
                val1 = 16'h2222;
                wait_grant(2'b10, 1'b1, "b2");
                req0 = 1'b0;
                wait_grant(2'b01, 1'b1, "b3");
                req1 = 1'b0;
            end
        join

        // Forced blanking keeps the scan phase.
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("c_pre_an", 32'(an), 32'b0111);
        blank_en = 1'b1;
        @(negedge clk);
        check("c_blk_an", 32'(an), 32'hF);
        check("c_blk_seg", 32'(seg), 32'hFF);
        repeat (9) @(negedge clk);
        check("c_hold_an", 32'(an), 32'hF);
        blank_en = 1'b0;
        @(negedge clk);
        check("c_rel_an", 32'(an), 32'b1011);
        check("c_rel_seg", 32'(seg), 32'h03);
        repeat (4) @(negedge clk);
        check("c_d2_an", 32'(an), 32'b1101);
        check("c_d2_seg", 32'(seg), 32'h03);

        // Mid-frame reset drops a pending write.
        @(negedge clk);
        rst = 1'b1;
        req0 = 1'b1;
        val0 = 16'h7777;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_grant(2'b10, 1'b0, "d0");
        req0 = 1'b0;
        repeat (14) @(negedge clk);
        check("d_pre_an", 32'(an), 32'b1011);
        #2;
        rst = 1'b1;
        #1;
        check("d_rst_an", 32'(an), 32'hF);
        check("d_rst_seg", 32'(seg), 32'hFF);
        check("d_rst_gnt", 32'({gnt0, gnt1}), 32'd0);
        sb_q.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        run_frames(2, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
